// File: rtl/bus_rsp_queue_if.sv
// Signal bundle between the coherence bus / Dmem / cores and the in-order response queue.
// The queue is the slave side; whoever drives requests, fills and acks is the master side.
interface bus_rsp_queue_if #(
  parameter int RSP_Q_PTR_W = 3,
  parameter int WORD_W      = 64,
  parameter int CORE_ID_W   = 1
);
  logic                   alloc_en_i;
  logic [CORE_ID_W-1:0]   alloc_core_id_i;
  logic [63:0]            alloc_addr_i;
  logic [RSP_Q_PTR_W-1:0] alloc_ptr_o;
  logic                   full_o;
  logic                   mem_rsp_vld_i;
  logic [RSP_Q_PTR_W-1:0] mem_rsp_ptr_i;
  logic [WORD_W-1:0]      mem_rsp_data_i;
  logic                   core_rsp_vld_i;
  logic [RSP_Q_PTR_W-1:0] core_rsp_ptr_i;
  logic [WORD_W-1:0]      core_rsp_data_i;
  logic                   wb_vld_o;
  logic [63:0]            wb_addr_o;
  logic [WORD_W-1:0]      wb_data_o;
  logic                   rsp_vld_o;
  logic [CORE_ID_W-1:0]   rsp_core_id_o;
  logic [63:0]            rsp_addr_o;
  logic [WORD_W-1:0]      rsp_data_o;
  logic                   rsp_ack_i;

  modport slave (
    input  alloc_en_i, alloc_core_id_i, alloc_addr_i,
    input  mem_rsp_vld_i, mem_rsp_ptr_i, mem_rsp_data_i,
    input  core_rsp_vld_i, core_rsp_ptr_i, core_rsp_data_i,
    input  rsp_ack_i,
    output alloc_ptr_o, full_o,
    output wb_vld_o, wb_addr_o, wb_data_o,
    output rsp_vld_o, rsp_core_id_o, rsp_addr_o, rsp_data_o
  );

  modport master (
    output alloc_en_i, alloc_core_id_i, alloc_addr_i,
    output mem_rsp_vld_i, mem_rsp_ptr_i, mem_rsp_data_i,
    output core_rsp_vld_i, core_rsp_ptr_i, core_rsp_data_i,
    output rsp_ack_i,
    input  alloc_ptr_o, full_o,
    input  wb_vld_o, wb_addr_o, wb_data_o,
    input  rsp_vld_o, rsp_core_id_o, rsp_addr_o, rsp_data_o
  );
endinterface

// File: rtl/bus_rsp_queue.sv
// In-order response queue: entries allocated at the tail, filled out of order by memory or
// an owning core, and retired from the head only once the head entry holds its data.
module bus_rsp_queue #(
  parameter int RSP_Q_NUM   = 8,
  parameter int RSP_Q_PTR_W = 3,
  parameter int WORD_W      = 64,
  parameter int CORE_ID_W   = 1
) (
  input logic            clk,
  input logic            rst,
  bus_rsp_queue_if.slave bus
);
  typedef enum logic [1:0] {
    ENT_FREE  = 2'd0,
    ENT_WAIT  = 2'd1,
    ENT_READY = 2'd2
  } ent_st_e;

  ent_st_e                st_q   [RSP_Q_NUM];
  ent_st_e                st_d   [RSP_Q_NUM];
  logic [63:0]            addr_q [RSP_Q_NUM];
  logic [WORD_W-1:0]      data_q [RSP_Q_NUM];
  logic [CORE_ID_W-1:0]   id_q   [RSP_Q_NUM];

  logic [RSP_Q_PTR_W:0]   head_q, head_d, tail_q, tail_d;
  logic [RSP_Q_PTR_W-1:0] head_idx, tail_idx;
  logic                   full, alloc_ok, mem_hit, core_hit, head_ready, pop;
  logic [RSP_Q_NUM-1:0]   alloc_sel, mem_sel, core_sel, pop_sel;

  assign head_idx = head_q[RSP_Q_PTR_W-1:0];
  assign tail_idx = tail_q[RSP_Q_PTR_W-1:0];

  // Wrap bit distinguishes full from empty when the indices coincide.
  assign full       = (head_idx == tail_idx) && (head_q[RSP_Q_PTR_W] != tail_q[RSP_Q_PTR_W]);
  assign alloc_ok   = bus.alloc_en_i && !full;
  assign mem_hit    = bus.mem_rsp_vld_i && (st_q[bus.mem_rsp_ptr_i] == ENT_WAIT);
  assign core_hit   = bus.core_rsp_vld_i && (st_q[bus.core_rsp_ptr_i] == ENT_WAIT);
  assign head_ready = (st_q[head_idx] == ENT_READY);
  assign pop        = bus.rsp_ack_i && head_ready;

  assign head_d = head_q + {{RSP_Q_PTR_W{1'b0}}, pop};
  assign tail_d = tail_q + {{RSP_Q_PTR_W{1'b0}}, alloc_ok};

  // Core data is the dirty owner copy, so it beats a memory fill to the same entry.
  generate
    for (genvar gi = 0; gi < RSP_Q_NUM; gi++) begin : g_sel
      assign alloc_sel[gi] = alloc_ok && (tail_idx == RSP_Q_PTR_W'(gi));
      assign core_sel[gi]  = core_hit && (bus.core_rsp_ptr_i == RSP_Q_PTR_W'(gi));
      assign mem_sel[gi]   = mem_hit && (bus.mem_rsp_ptr_i == RSP_Q_PTR_W'(gi)) && !core_sel[gi];
      assign pop_sel[gi]   = pop && (head_idx == RSP_Q_PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < RSP_Q_NUM; i++) begin
      st_d[i] = st_q[i];
      if (alloc_sel[i]) begin
        st_d[i] = ENT_WAIT;
      end else if (core_sel[i] || mem_sel[i]) begin
        st_d[i] = ENT_READY;
      end else if (pop_sel[i]) begin
        st_d[i] = ENT_FREE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < RSP_Q_NUM; i++) begin
        st_q[i]   <= ENT_FREE;
        addr_q[i] <= '0;
        data_q[i] <= '0;
        id_q[i]   <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int i = 0; i < RSP_Q_NUM; i++) begin
        st_q[i] <= st_d[i];
        if (alloc_sel[i]) begin
          addr_q[i] <= bus.alloc_addr_i;
          id_q[i]   <= bus.alloc_core_id_i;
        end
        if (core_sel[i]) begin
          data_q[i] <= bus.core_rsp_data_i;
        end else if (mem_sel[i]) begin
          data_q[i] <= bus.mem_rsp_data_i;
        end
      end
    end
  end

  assign bus.alloc_ptr_o   = tail_idx;
  assign bus.full_o        = full;
  assign bus.wb_vld_o      = core_hit;
  assign bus.wb_addr_o     = addr_q[bus.core_rsp_ptr_i];
  assign bus.wb_data_o     = bus.core_rsp_data_i;
  assign bus.rsp_vld_o     = head_ready;
  assign bus.rsp_core_id_o = id_q[head_idx];
  assign bus.rsp_addr_o    = addr_q[head_idx];
  assign bus.rsp_data_o    = data_q[head_idx];
endmodule
